ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: settings shared by the RAM arbiter and its round-robin sub-block.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   req_id_t                : requester identifier (0 = m0, 1 = m1)
//   id_from_gnt()           : turns a one-hot grant vector into a requester ID
package ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_t;

  // A one-hot grant with bit 1 set belongs to m1; every other value maps to m0.
  function automatic req_id_t id_from_gnt(input logic [1:0] gnt);
    req_id_t id;
    if (gnt[1]) begin
      id = REQ_M1;
    end else begin
      id = REQ_M0;
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: purely combinational two-way round-robin selector.
//   req[1:0] : request vector (bit 0 = m0, bit 1 = m1)
//   ptr      : requester that wins when both request (0 = m0, 1 = m1)
//   gnt[1:0] : one-hot grant, all zero when nobody requests
module rr_arb2
  import ram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (ptr == REQ_M1) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
//   clk, rst                       : clock, asynchronous active-high reset
//   mN_req/mN_wr/mN_addr/mN_wdata  : requester N command (N = 0, 1)
//   mN_gnt                         : combinational grant; transfer on req & gnt at the edge
//   mN_rvalid/mN_rdata             : read return for requester N
//   cen/wen/s_addr/s_din           : registered RAM command
//   s_dout                         : RAM read data, valid the cycle after a read command
// Pipeline: accept in t, RAM command in t+1, read data returned in t+2.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout
);

  logic              ptr;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              xfer;
  req_id_t           gnt_id;
  req_id_t           cmd_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req ({m1_req, m0_req}),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Grants are suppressed while reset is held so nothing is accepted mid-reset.
  always_comb begin
    if (rst) begin
      gnt = 2'b00;
    end else begin
      gnt = arb_gnt;
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign xfer   = gnt[0] | gnt[1];
  assign gnt_id = id_from_gnt(gnt);

  // Steer the granted requester's command toward the command register.
  always_comb begin
    if (gnt[1]) begin
      sel_wr    = m1_wr;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else begin
      sel_wr    = m0_wr;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  // Round-robin pointer: after a transfer it points at the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= REQ_M0;
    end else if (xfer) begin
      ptr <= (gnt_id == REQ_M0) ? REQ_M1 : REQ_M0;
    end else begin
      ptr <= ptr;
    end
  end

  // Command stage: cen pulses per transfer, the other RAM fields hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen    <= 1'b0;
      wen    <= 1'b0;
      s_addr <= '0;
      s_din  <= '0;
      cmd_id <= REQ_M0;
    end else begin
      cen <= xfer;
      if (xfer) begin
        wen    <= sel_wr;
        s_addr <= sel_addr;
        s_din  <= sel_wdata;
        cmd_id <= gnt_id;
      end else begin
        wen    <= wen;
        s_addr <= s_addr;
        s_din  <= s_din;
        cmd_id <= cmd_id;
      end
    end
  end

  // Return stage: a read command in the RAM this cycle yields data next cycle,
  // routed to the requester whose ID travelled with the command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= cen & ~wen & (cmd_id == REQ_M0);
      m1_rvalid <= cen & ~wen & (cmd_id == REQ_M1);
    end
  end

  assign m0_rdata = s_dout;
  assign m1_rdata = s_dout;

endmodule
